// File: rtl/acq_sequencer.sv
// ----------------------------------------------------------------------------
// acq_sequencer
//
// Purpose:
//   Run-control sequencer placed between the RBCP register bank, the
//   per-channel sample sources and the SiTCP TX packer. A rising edge on
//   trigger_cmd captures data_number / channel_ctrl into shadow registers.
//   The sequencer then walks the enabled channels in ascending order. For
//   every enabled channel it emits one header word followed by data_number
//   samples taken from the selected source. At the end it pulses
//   trigger_clr and done together. An abort ends the run early: it pulses
//   trigger_clr only.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   trigger_cmd            level from register bank; rising edge starts a run
//   data_number[31:0]      samples per enabled channel
//   channel_ctrl[N_CH-1:0] channel enable mask
//   abort                  synchronous abort request (level)
//   trigger_clr            1-cycle pulse, register bank clears trigger_cmd
//   ch_sel[2:0]            channel index driving the external source mux
//   src_valid/src_data/src_ready   selected source stream
//   out_valid/out_data/out_last/out_ready   output stream to the packer
//   busy                   high while a run is in progress
//   done                   1-cycle pulse at the end of a normal or empty run
// ----------------------------------------------------------------------------
module acq_sequencer #(
  parameter int          DATA_W    = 32,
  parameter int          N_CH      = 8,
  parameter logic [7:0]  HDR_MAGIC = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger_cmd,
  input  logic [31:0]       data_number,
  input  logic [N_CH-1:0]   channel_ctrl,
  input  logic              abort,
  output logic              trigger_clr,
  output logic [2:0]        ch_sel,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // Scan pointer must be able to hold N_CH ("past the last channel").
  localparam int PTR_W = $clog2(N_CH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_HDR,
    S_STREAM,
    S_FIN
  } state_t;

  state_t              state_reg, state_next;
  logic                trigger_q_reg;
  logic [31:0]         count_reg, count_next;
  logic [N_CH-1:0]     mask_reg, mask_next;
  logic [PTR_W-1:0]    scan_ptr_reg, scan_ptr_next;
  logic [2:0]          ch_sel_reg, ch_sel_next;
  logic [31:0]         sample_cnt_reg, sample_cnt_next;
  logic                out_valid_reg, out_valid_next;
  logic [DATA_W-1:0]   out_data_reg, out_data_next;
  logic                out_last_reg, out_last_next;
  logic                busy_reg, busy_next;
  logic                abort_clr_reg, abort_clr_next;

  logic                trig_rise;
  logic [N_CH-1:0]     eligible;
  logic                found;
  logic [2:0]          found_idx;
  logic [2:0]          last_ch;
  logic [31:0]         hdr_word;
  logic [31:0]         cnt_inc;
  logic                last_sample;
  logic                done_c;
  logic                src_ready_c;

  assign trig_rise = trigger_cmd & ~trigger_q_reg;

  // Channels still to be visited: enabled and at or above the scan pointer.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_elig
      assign eligible[gi] = mask_reg[gi] && (PTR_W'(gi) >= scan_ptr_reg);
    end
  endgenerate

  // Lowest eligible channel, and highest enabled channel (the one whose
  // final sample carries out_last).
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found     = 1'b1;
        found_idx = 3'(i);
      end
    end
    last_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (mask_reg[i]) begin
        last_ch = 3'(i);
      end
    end
  end

  assign hdr_word    = {HDR_MAGIC, 5'd0, found_idx, count_reg[15:0]};
  // Counter only ever runs 0..count-1, so the increment cannot wrap even
  // for count = 32'hFFFF_FFFF.
  assign cnt_inc     = sample_cnt_reg + 32'd1;
  assign last_sample = (cnt_inc == count_reg);

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    mask_next       = mask_reg;
    scan_ptr_next   = scan_ptr_reg;
    ch_sel_next     = ch_sel_reg;
    sample_cnt_next = sample_cnt_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_last_next   = out_last_reg;
    busy_next       = busy_reg;
    abort_clr_next  = 1'b0;
    src_ready_c     = 1'b0;
    done_c          = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Abort present in the same cycle as the edge suppresses the run.
        if (trig_rise && !abort) begin
          count_next    = data_number;
          mask_next     = channel_ctrl;
          scan_ptr_next = '0;
          busy_next     = 1'b1;
          state_next    = S_SCAN;
        end
      end

      S_SCAN: begin
        // The previous channel's last sample may still sit in the output
        // stage; let it drain.
        if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          out_last_next  = 1'b0;
        end
        if ((count_reg == 32'd0) || !found) begin
          state_next = S_FIN;
        end else if (!out_valid_reg || out_ready) begin
          // Stage is free at this edge: load the header directly.
          ch_sel_next     = found_idx;
          out_data_next   = DATA_W'(hdr_word);
          out_valid_next  = 1'b1;
          out_last_next   = 1'b0;
          sample_cnt_next = '0;
          state_next      = S_HDR;
        end
      end

      S_HDR: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = S_STREAM;
        end
      end

      S_STREAM: begin
        src_ready_c = !out_valid_reg || out_ready;
        if (src_valid && src_ready_c) begin
          out_data_next   = src_data;
          out_valid_next  = 1'b1;
          out_last_next   = last_sample && (ch_sel_reg == last_ch);
          sample_cnt_next = cnt_inc;
          if (last_sample) begin
            scan_ptr_next = PTR_W'(ch_sel_reg) + PTR_W'(1);
            state_next    = S_SCAN;
          end
        end else if (out_ready) begin
          out_valid_next = 1'b0;
          out_last_next  = 1'b0;
        end
      end

      S_FIN: begin
        if (out_valid_reg) begin
          if (out_ready) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
          end
        end else begin
          done_c     = 1'b1;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE, including a pending done.
    if (abort && (state_reg != S_IDLE)) begin
      state_next     = S_IDLE;
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
      busy_next      = 1'b0;
      abort_clr_next = 1'b1;
      src_ready_c    = 1'b0;
      done_c         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      trigger_q_reg  <= 1'b0;
      count_reg      <= '0;
      mask_reg       <= '0;
      scan_ptr_reg   <= '0;
      ch_sel_reg     <= '0;
      sample_cnt_reg <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      abort_clr_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      trigger_q_reg  <= trigger_cmd;
      count_reg      <= count_next;
      mask_reg       <= mask_next;
      scan_ptr_reg   <= scan_ptr_next;
      ch_sel_reg     <= ch_sel_next;
      sample_cnt_reg <= sample_cnt_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_last_reg   <= out_last_next;
      busy_reg       <= busy_next;
      abort_clr_reg  <= abort_clr_next;
    end
  end

  assign ch_sel      = ch_sel_reg;
  assign src_ready   = src_ready_c;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_last    = out_last_reg;
  assign busy        = busy_reg;
  assign done        = done_c;
  assign trigger_clr = done_c | abort_clr_reg;

endmodule
